spmv_config_axil_master: RTL and testbench

//  AXI4-Lite initiator that programs and reads back the SpMV vector-loader config registers
//  (mode 0x00, HBM base addr 0x08/0x0C, HBM now addr 0x10/0x14) from a simple cmd/rsp stream.

---
 rtl/spmv_cfg_pkg.sv | 9 +
 rtl/spmv_config_axil_master.sv | 159 +++++++++++++++
 tb/tb_spmv_config_axil_master.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spmv_cfg_pkg.sv
// spmv_cfg_pkg: FSM states, AXI resp codes and loader register offsets for the SpMV config master
package spmv_cfg_pkg;
  typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [7:0] CONF_LOADER_MODE = 8'h00;
  localparam logic [7:0] CONF_HBM_BASE_ADDR = 8'h08;
  localparam logic [7:0] CONF_HBM_NOW_ADDR = 8'h10;
endpackage

// File: rtl/spmv_config_axil_master.sv
// spmv_config_axil_master: one-outstanding AXI4-Lite initiator driven by a cmd/rsp stream
// Ports: aclk/aresetn (async active-low); cmd_* request stream (we, addr, wdata);
// rsp_* response stream (rdata, resp, timeout); busy; m_axil_* AXI4-Lite master channels.
// All AXI and rsp outputs are registered.
module spmv_config_axil_master
  import spmv_cfg_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              m_axil_awvalid,
  output logic [ADDR_W-1:0] m_axil_awaddr,
  input  logic              m_axil_awready,
  output logic              m_axil_wvalid,
  output logic [DATA_W-1:0] m_axil_wdata,
  input  logic              m_axil_wready,
  input  logic              m_axil_bvalid,
  input  logic [1:0]        m_axil_bresp,
  output logic              m_axil_bready,
  output logic              m_axil_arvalid,
  output logic [ADDR_W-1:0] m_axil_araddr,
  input  logic              m_axil_arready,
  input  logic              m_axil_rvalid,
  input  logic [DATA_W-1:0] m_axil_rdata,
  input  logic [1:0]        m_axil_rresp,
  output logic              m_axil_rready
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic act, done;
  // done: the current AXI phase completes at this edge, which takes priority over a timeout
  always_comb begin
    act = state inside {WR, WB, RA, RD};
    done = state == WR ? (!m_axil_awvalid || m_axil_awready) && (!m_axil_wvalid || m_axil_wready)
         : state == WB ? m_axil_bvalid
         : state == RA ? m_axil_arready
         : state == RD ? m_axil_rvalid : 1'b0;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      cnt <= '0;
      cmd_ready <= 1'b0;
      busy <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp <= '0;
      rsp_timeout <= 1'b0;
      m_axil_awvalid <= 1'b0;
      m_axil_awaddr <= '0;
      m_axil_wvalid <= 1'b0;
      m_axil_wdata <= '0;
      m_axil_bready <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_araddr <= '0;
      m_axil_rready <= 1'b0;
    end else begin
      if (act) cnt <= cnt + 1'b1;
      case (state)
        // readies come up one cycle after reset; IDLE keeps B/R open to drain stray responses
        IDLE: if (cmd_valid && cmd_ready) begin
          cmd_ready <= 1'b0;
          m_axil_bready <= 1'b0;
          m_axil_rready <= 1'b0;
          busy <= 1'b1;
          cnt <= '0;
          if (cmd_addr[1:0] != 2'b00) begin
            state <= RSP;
            rsp_valid <= 1'b1;
            rsp_resp <= RESP_SLVERR;
            rsp_rdata <= '0;
            rsp_timeout <= 1'b0;
          end else if (cmd_we) begin
            state <= WR;
            m_axil_awvalid <= 1'b1;
            m_axil_wvalid <= 1'b1;
            m_axil_awaddr <= cmd_addr;
            m_axil_wdata <= cmd_wdata;
          end else begin
            state <= RA;
            m_axil_arvalid <= 1'b1;
            m_axil_araddr <= cmd_addr;
          end
        end else begin
          cmd_ready <= 1'b1;
          m_axil_bready <= 1'b1;
          m_axil_rready <= 1'b1;
        end
        WR: begin
          if (m_axil_awready) m_axil_awvalid <= 1'b0;
          if (m_axil_wready) m_axil_wvalid <= 1'b0;
          if (done) begin
            state <= WB;
            m_axil_bready <= 1'b1;
          end
        end
        WB: if (m_axil_bvalid) begin
          state <= RSP;
          m_axil_bready <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_resp <= m_axil_bresp;
          rsp_rdata <= '0;
          rsp_timeout <= 1'b0;
        end
        RA: if (m_axil_arready) begin
          state <= RD;
          m_axil_arvalid <= 1'b0;
          m_axil_rready <= 1'b1;
        end
        RD: if (m_axil_rvalid) begin
          state <= RSP;
          m_axil_rready <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_resp <= m_axil_rresp;
          rsp_rdata <= m_axil_rdata;
          rsp_timeout <= 1'b0;
        end
        RSP: if (rsp_ready) begin
          state <= IDLE;
          rsp_valid <= 1'b0;
          busy <= 1'b0;
          cmd_ready <= 1'b1;
          m_axil_bready <= 1'b1;
          m_axil_rready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      // abort overrides whatever the phase logic above scheduled
      if (act && !done && cnt == TMAX) begin
        state <= RSP;
        m_axil_awvalid <= 1'b0;
        m_axil_wvalid <= 1'b0;
        m_axil_arvalid <= 1'b0;
        m_axil_bready <= 1'b0;
        m_axil_rready <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_resp <= RESP_SLVERR;
        rsp_rdata <= '0;
        rsp_timeout <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spmv_config_axil_master.sv
// tb_spmv_config_axil_master: directed + randomized bench with a behavioural AXI-Lite slave and register model
module tb_spmv_config_axil_master;
  import spmv_cfg_pkg::*;
  localparam int TO = 16;
  logic clk = 1'b0, aresetn = 1'b0;
  always #5 clk = ~clk;
  logic cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [1:0] bresp, rresp;
  int total = 0, bad = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit b_en = 1, r_en = 1;
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  logic [31:0] last_aw, last_w, last_ar;
  logic [31:0] smem [0:7];
  logic [31:0] regs [0:7];
  logic [7:0] aw_tr, w_tr;

  spmv_config_axil_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .aclk(clk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .m_axil_awvalid(awvalid), .m_axil_awaddr(awaddr), .m_axil_awready(awready),
    .m_axil_wvalid(wvalid), .m_axil_wdata(wdata), .m_axil_wready(wready),
    .m_axil_bvalid(bvalid), .m_axil_bresp(bresp), .m_axil_bready(bready),
    .m_axil_arvalid(arvalid), .m_axil_araddr(araddr), .m_axil_arready(arready),
    .m_axil_rvalid(rvalid), .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rready(rready)
  );

  // Slave: decides its inputs at each negedge and predicts which handshakes the next posedge completes.
  initial begin : slave
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, got_aw, got_w, got_ar;
    int aw_c, w_c, b_c, ar_c, r_c;
    {aw_hs, w_hs, b_hs, ar_hs, r_hs, got_aw, got_w, got_ar} = '0;
    {aw_c, w_c, b_c, ar_c, r_c} = '0;
    {awready, wready, bvalid, arready, rvalid} = '0;
    bresp = '0; rresp = '0; rdata = '0;
    for (int i = 0; i < 8; i++) smem[i] = '0;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        {awready, wready, bvalid, arready, rvalid} = '0;
        {aw_hs, w_hs, b_hs, ar_hs, r_hs, got_aw, got_w, got_ar} = '0;
        {aw_c, w_c, b_c, ar_c, r_c} = '0;
      end else begin
        if (aw_hs) begin got_aw = 1; n_aw++; end
        if (w_hs) begin got_w = 1; n_w++; end
        if (b_hs) begin bvalid = 0; n_b++; end
        if (ar_hs) begin got_ar = 1; n_ar++; end
        if (r_hs) begin rvalid = 0; n_r++; end
        if (got_aw && got_w && !bvalid) begin
          if (b_en && b_c >= b_dly) begin
            bvalid = 1; bresp = RESP_OKAY; smem[last_aw[4:2]] = last_w; got_aw = 0; got_w = 0; b_c = 0;
          end else b_c++;
        end
        if (got_ar && !rvalid) begin
          if (r_en && r_c >= r_dly) begin
            rvalid = 1; rresp = RESP_OKAY; rdata = smem[last_ar[4:2]]; got_ar = 0; r_c = 0;
          end else r_c++;
        end
        awready = awvalid && aw_c >= aw_dly;
        aw_c = awready ? 0 : aw_c + int'(awvalid);
        wready = wvalid && w_c >= w_dly;
        w_c = wready ? 0 : w_c + int'(wvalid);
        arready = arvalid && ar_c >= ar_dly;
        ar_c = arready ? 0 : ar_c + int'(arvalid);
        aw_hs = awvalid && awready; if (aw_hs) last_aw = awaddr;
        w_hs = wvalid && wready; if (w_hs) last_w = wdata;
        ar_hs = arvalid && arready; if (ar_hs) last_ar = araddr;
        b_hs = bvalid && bready;
        r_hs = rvalid && rready;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Called at a negedge with the DUT idle. lat = edges after accept before rsp_valid is visible.
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, output int lat, output logic ok);
    int n = 0;
    ok = 0; lat = -1;
    cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) begin cmd_valid = 0; return; end
    @(negedge clk);
    cmd_valid = 0;
    aw_tr = '0; w_tr = '0;
    for (int i = 0; i < 100; i++) begin
      if (i < 8) begin aw_tr[i] = awvalid; w_tr[i] = wvalid; end
      if (rsp_valid) begin lat = i; ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic consume();
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({cmd_ready, awvalid, wvalid, arvalid, bready, rready, busy} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0", {cmd_ready, awvalid, wvalid, arvalid, bready, rready, busy});
    end
    total++;
    if ({rsp_valid, rsp_rdata, rsp_resp, rsp_timeout} !== 36'b0) begin
      bad++; $display("FAIL reset_rsp got=%h want=0", {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout});
    end
    aresetn = 1;
    repeat (2) @(negedge clk);
    total++;
    if ({cmd_ready, bready, rready, busy} !== 4'b1110) begin
      bad++; $display("FAIL idle_after_reset got=%b want=1110", {cmd_ready, bready, rready, busy});
    end
  endtask

  task automatic test_write_zero_wait();
    int lat, b0, aw0; logic ok;
    b0 = n_b; aw0 = n_aw;
    issue(1, 32'(CONF_LOADER_MODE), 32'h3, lat, ok);
    regs[0] = 32'h3;
    total++;
    if (!ok || lat != 2) begin bad++; $display("FAIL wr0_latency got=%0d want=2", lat); end
    total++;
    if ({aw_tr[0], w_tr[0]} !== 2'b11) begin bad++; $display("FAIL wr0_awv_wv_t1 got=%b want=11", {aw_tr[0], w_tr[0]}); end
    total++;
    if ({rsp_rdata, rsp_resp, rsp_timeout} !== {32'h0, RESP_OKAY, 1'b0}) begin
      bad++; $display("FAIL wr0_rsp got=%h want=0", {rsp_rdata, rsp_resp, rsp_timeout});
    end
    consume();
    total++;
    if (n_b - b0 != 1 || n_aw - aw0 != 1 || last_aw !== 32'h0 || smem[0] !== 32'h3) begin
      bad++; $display("FAIL wr0_slave got b=%0d aw=%0d addr=%h mem=%h want 1 1 0 3", n_b - b0, n_aw - aw0, last_aw, smem[0]);
    end
  endtask

  task automatic test_write_aw_late();
    int lat; logic ok;
    aw_dly = 3;
    issue(1, 32'(CONF_HBM_BASE_ADDR), 32'hDEAD_BEEF, lat, ok);
    regs[2] = 32'hDEAD_BEEF;
    total++;
    if ({aw_tr[1:0], w_tr[1:0]} !== 4'b1101) begin
      bad++; $display("FAIL wr_late_w_first got aw=%b w=%b want aw=11 w=01", aw_tr[1:0], w_tr[1:0]);
    end
    total++;
    if (!ok || lat != 5 || rsp_resp !== RESP_OKAY || rsp_timeout !== 1'b0) begin
      bad++; $display("FAIL wr_late_rsp got lat=%0d resp=%0d to=%b want 5 0 0", lat, rsp_resp, rsp_timeout);
    end
    consume();
    aw_dly = 0;
    total++;
    if (last_aw !== 32'h8 || smem[2] !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL wr_late_slave got addr=%h mem=%h want 8 deadbeef", last_aw, smem[2]);
    end
  endtask

  task automatic test_read_hold();
    int lat; logic ok;
    issue(1, 32'h0C, 32'h1234_5678, lat, ok);
    regs[3] = 32'h1234_5678;
    consume();
    issue(0, 32'h0C, 32'h0, lat, ok);
    total++;
    if (!ok || lat != 2 || last_ar !== 32'h0C) begin bad++; $display("FAIL rd_latency got lat=%0d ar=%h want 2 c", lat, last_ar); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp_valid, rsp_rdata, rsp_resp, rsp_timeout} !== {1'b1, regs[3], RESP_OKAY, 1'b0}) begin
        bad++; $display("FAIL rd_hold%0d got=%h want=%h", i, {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout}, {1'b1, regs[3], RESP_OKAY, 1'b0});
      end
      @(negedge clk);
    end
    consume();
  endtask

  task automatic test_misaligned();
    int lat, aw0, ar0; logic ok;
    aw0 = n_aw; ar0 = n_ar;
    issue(1, 32'h06, 32'hFFFF_FFFF, lat, ok);
    total++;
    if (!ok || lat != 0 || {rsp_rdata, rsp_resp, rsp_timeout} !== {32'h0, RESP_SLVERR, 1'b0}) begin
      bad++; $display("FAIL misalign_rsp got lat=%0d rsp=%h want lat=0 rsp=%h", lat, {rsp_rdata, rsp_resp, rsp_timeout}, {32'h0, RESP_SLVERR, 1'b0});
    end
    total++;
    if ({aw_tr[0], w_tr[0], awvalid, wvalid, arvalid} !== 5'b0) begin
      bad++; $display("FAIL misalign_axi got=%b want=0", {aw_tr[0], w_tr[0], awvalid, wvalid, arvalid});
    end
    consume();
    total++;
    if (n_aw != aw0 || n_ar != ar0) begin bad++; $display("FAIL misalign_traffic got aw=%0d ar=%0d want 0 0", n_aw - aw0, n_ar - ar0); end
  endtask

  task automatic test_timeout();
    int lat, b0; logic ok; logic [31:0] d;
    d = $urandom;
    b_en = 0;
    b0 = n_b;
    issue(1, 32'(CONF_HBM_NOW_ADDR), d, lat, ok);
    total++;
    if (!ok || lat != TO) begin bad++; $display("FAIL to_latency got=%0d want=%0d", lat, TO); end
    total++;
    if ({rsp_rdata, rsp_resp, rsp_timeout} !== {32'h0, RESP_SLVERR, 1'b1}) begin
      bad++; $display("FAIL to_rsp got=%h want=%h", {rsp_rdata, rsp_resp, rsp_timeout}, {32'h0, RESP_SLVERR, 1'b1});
    end
    b_en = 1;
    regs[4] = d;
    consume();
    for (int i = 0; i < 10 && n_b == b0; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin bad++; $display("FAIL stray_b_rsp got=%b want=0", rsp_valid); end
    end
    @(negedge clk);
    total++;
    if (n_b - b0 != 1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL stray_b_absorb got b=%0d busy=%b rv=%b want 1 0 0", n_b - b0, busy, rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat, n; logic ok;
    r_en = 0;
    cmd_valid = 1; cmd_we = 0; cmd_addr = 32'h08;
    n = 0;
    while (!(busy && rready) && n < 20) begin @(negedge clk); n++; end
    cmd_valid = 0;
    total++;
    if (!(busy && rready)) begin bad++; $display("FAIL rst_mid_reach_rd got busy=%b rready=%b want 1 1", busy, rready); end
    #2 aresetn = 0;
    #1;
    total++;
    if ({arvalid, rready, rsp_valid, busy} !== 4'b0) begin
      bad++; $display("FAIL rst_mid_immediate got=%b want=0", {arvalid, rready, rsp_valid, busy});
    end
    r_en = 1;
    repeat (2) @(negedge clk);
    aresetn = 1;
    issue(0, 32'h08, 32'h0, lat, ok);
    total++;
    if (!ok || {rsp_rdata, rsp_resp, rsp_timeout} !== {regs[2], RESP_OKAY, 1'b0}) begin
      bad++; $display("FAIL rst_mid_next got=%h want=%h", {rsp_rdata, rsp_resp, rsp_timeout}, {regs[2], RESP_OKAY, 1'b0});
    end
    consume();
  endtask

  task automatic test_random();
    int lat, aw0, ar0, idx; logic ok, we, mis; logic [31:0] a, d, exp_d; logic [1:0] exp_r;
    for (int k = 0; k < 30; k++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      idx = $urandom_range(0, 5);
      mis = $urandom_range(0, 7) == 0;
      we = 1'($urandom_range(0, 1));
      d = $urandom;
      a = 32'(idx * 4) | (mis ? 32'($urandom_range(1, 3)) : 32'h0);
      aw0 = n_aw; ar0 = n_ar;
      exp_d = (mis || we) ? 32'h0 : regs[idx];
      exp_r = mis ? RESP_SLVERR : RESP_OKAY;
      if (!mis && we) regs[idx] = d;
      issue(we, a, d, lat, ok);
      total++;
      if (!ok || {rsp_rdata, rsp_resp, rsp_timeout} !== {exp_d, exp_r, 1'b0}) begin
        bad++; $display("FAIL rand%0d_rsp addr=%h we=%b got=%h want=%h", k, a, we, {rsp_rdata, rsp_resp, rsp_timeout}, {exp_d, exp_r, 1'b0});
      end
      consume();
      total++;
      if (n_aw - aw0 != int'(!mis && we) || n_ar - ar0 != int'(!mis && !we)) begin
        bad++; $display("FAIL rand%0d_traffic got aw=%0d ar=%0d want %0d %0d", k, n_aw - aw0, n_ar - ar0, int'(!mis && we), int'(!mis && !we));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = '0;
    test_reset();
    test_write_zero_wait();
    test_write_aw_late();
    test_read_hold();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
